// File: rtl/wb_spi_flash_reader.sv
// wb_spi_flash_reader: read-only Wishbone classic window onto an SPI NOR flash (0x03 READ command).
// Latency: ack and data arrive 128*CLK_DIV clocks after the accepting edge; write err arrives the next cycle.
// Backpressure: one transfer at a time; stb is held un-acked until the whole word has been shifted in.
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; wb_adr_i/wb_we_i/wb_cyc_i/wb_stb_i request
//        (wb_dat_i, wb_sel_i ignored); wb_dat_o/wb_ack_o/wb_err_o response; sck_o/cs_n_o/mosi_o/miso_i SPI mode 0.
module wb_spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        sck_o,
  output logic        cs_n_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       dat_q, dat_d;

  logic              accept;
  logic              div_wrap;
  logic              last_bit;
  logic [63:0]       tx_load;

  // Data and byte-select are meaningless for a read-only word port; the
  // interconnect has already decoded the upper address bits.
  logic unused_ok;
  assign unused_ok = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:24], wb_adr_i[1:0]};

  // The ack/err guard stops the same stb being taken twice while the master
  // is still looking at our response.
  assign accept   = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign div_wrap = (div_cnt_q == DIV_MAX);
  // Falling toggle of the 64th bit ends the transfer.
  assign last_bit = wb_cyc_i & div_wrap & sck_q & (bit_cnt_q == 6'd63);
  // Command, word-aligned 24-bit address, then 32 dummy bits clocked out
  // while the data word is clocked in.
  assign tx_load  = {8'h03, wb_adr_i[23:2], 2'b00, 32'h0};

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !wb_we_i) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!wb_cyc_i || last_bit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values (all outputs are registered)
  always_comb begin
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    dat_d     = dat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (wb_we_i) begin
            err_d = 1'b1;
          end else begin
            tx_d      = tx_load;
            cs_n_d    = 1'b0;
            sck_d     = 1'b0;
            mosi_d    = tx_load[63];
            div_cnt_d = '0;
            bit_cnt_d = '0;
          end
        end
      end
      ST_SHIFT: begin
        if (!wb_cyc_i) begin
          // Master abandoned the cycle: release the flash, leave data alone.
          cs_n_d = 1'b1;
          sck_d  = 1'b0;
          mosi_d = 1'b0;
        end else if (div_wrap) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          if (!sck_q) begin
            // Rising toggle: only the last 32 bits survive in rx.
            rx_d = {rx_q[30:0], miso_i};
          end else if (last_bit) begin
            cs_n_d = 1'b1;
            ack_d  = 1'b1;
            // First byte off the wire is the lowest-addressed byte.
            dat_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            tx_d      = {tx_q[62:0], 1'b0};
            mosi_d    = tx_q[62];
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign sck_o    = sck_q;
  assign cs_n_o   = cs_n_q;
  assign mosi_o   = mosi_q;

endmodule

// File: tb/tb_wb_spi_flash_reader.sv
// tb_wb_spi_flash_reader: drives two readers (CLK_DIV=1 and CLK_DIV=2) sharing one behavioural SPI flash.
// The flash model decodes command/address from MOSI and serves bytes on MISO; expected words come
// from the flash contents function, independent of the wire traffic.
module tb_wb_spi_flash_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc1, stb1, cyc2, stb2;
  logic        miso;

  logic [31:0] dat1, dat2;
  logic        ack1, err1, sck1, cs1, mosi1;
  logic        ack2, err2, sck2, cs2, mosi2;

  wb_spi_flash_reader #(.CLK_DIV(1)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb1), .wb_dat_o(dat1), .wb_ack_o(ack1),
    .wb_err_o(err1), .sck_o(sck1), .cs_n_o(cs1), .mosi_o(mosi1), .miso_i(miso)
  );

  wb_spi_flash_reader #(.CLK_DIV(2)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc2), .wb_stb_i(stb2), .wb_dat_o(dat2), .wb_ack_o(ack2),
    .wb_err_o(err2), .sck_o(sck2), .cs_n_o(cs2), .mosi_o(mosi2), .miso_i(miso)
  );

  // The flash listens to whichever reader is selected (switched only while both idle).
  logic        use1;
  logic        m_sck, m_cs_n, m_mosi, m_ack;
  logic [31:0] m_dat;
  assign m_sck  = use1 ? sck1  : sck2;
  assign m_cs_n = use1 ? cs1   : cs2;
  assign m_mosi = use1 ? mosi1 : mosi2;
  assign m_ack  = use1 ? ack1  : ack2;
  assign m_dat  = use1 ? dat1  : dat2;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // ---------------- flash contents and reference model ----------------
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000104: return 8'h11;
      24'h000105: return 8'h22;
      24'h000106: return 8'h33;
      24'h000107: return 8'h44;
      default:    return a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ a[23:16] ^ 8'h5C;
    endcase
  endfunction

  // Aligned word, little-endian: lowest address in bits [7:0].
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [23:0] b;
    b = {a[23:2], 2'b00};
    return {flash_byte(b + 24'd3), flash_byte(b + 24'd2), flash_byte(b + 24'd1), flash_byte(b)};
  endfunction

  // ---------------- behavioural SPI flash (mode 0) ----------------
  int          in_bits  = 0;
  int          out_bits = 0;
  logic [31:0] cap      = '0;
  logic [7:0]  fb_tmp;

  always @(negedge m_cs_n) begin
    in_bits  = 0;
    out_bits = 0;
    cap      = '0;
  end

  always @(posedge m_sck) begin
    if (m_cs_n === 1'b0) begin
      if (in_bits < 32) cap = {cap[30:0], m_mosi};
      in_bits++;
    end
  end

  always @(negedge m_sck) begin
    if (m_cs_n === 1'b0 && in_bits >= 32) begin
      fb_tmp   = flash_byte(cap[23:0] + 24'(out_bits / 8));
      miso     = fb_tmp[7 - (out_bits % 8)];
      out_bits++;
    end
  end

  // ---------------- read driver (records observed timing) ----------------
  int          r_acc, r_ack, r_first_rise, r_rises;
  logic [31:0] r_data;
  logic        r_cs_at_ack;

  // Called at a negedge; returns at the negedge where ack is seen.
  task automatic run_read(input bit d1, input logic [31:0] addr, input bit keep);
    logic prev_sck;
    bit   done;
    use1 = d1; we = 1'b0; adr = addr; wdat = $urandom; sel = 4'hF;
    if (d1) begin cyc1 = 1'b1; stb1 = 1'b1; end
    else    begin cyc2 = 1'b1; stb2 = 1'b1; end
    r_acc = -1; r_ack = -1; r_first_rise = -1; r_rises = 0; r_cs_at_ack = 1'b0; r_data = '0;
    prev_sck = m_sck;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (r_acc < 0 && m_cs_n === 1'b0) r_acc = edge_cnt;
      if (m_sck === 1'b1 && prev_sck === 1'b0) begin
        r_rises++;
        if (r_first_rise < 0) r_first_rise = edge_cnt;
      end
      prev_sck = m_sck;
      if (m_ack === 1'b1) begin
        r_ack = edge_cnt; r_data = m_dat; r_cs_at_ack = m_cs_n; done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL read_timeout: addr %h got no ack in 3000 cycles, required an ack", addr);
    end
    if (!keep) begin cyc1 = 1'b0; stb1 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dat2, ack2, err2, sck2, cs2, mosi2} !== {32'h0, 5'b00010}) begin
      n_fail++;
      $display("FAIL reset_dut2: got dat=%h ack=%b err=%b sck=%b cs_n=%b mosi=%b, required 0/0/0/0/1/0",
               dat2, ack2, err2, sck2, cs2, mosi2);
    end
    n_checks++;
    if ({dat1, ack1, err1, sck1, cs1, mosi1} !== {32'h0, 5'b00010}) begin
      n_fail++;
      $display("FAIL reset_dut1: got dat=%h ack=%b err=%b sck=%b cs_n=%b mosi=%b, required 0/0/0/0/1/0",
               dat1, ack1, err1, sck1, cs1, mosi1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_read();
    @(negedge clk);
    run_read(1'b0, 32'h0000_0104, 1'b0);
    n_checks++;
    if (cap !== 32'h0300_0104) begin n_fail++; $display("FAIL basic_mosi: got %h required %h", cap, 32'h0300_0104); end
    n_checks++;
    if (r_data !== 32'h4433_2211) begin n_fail++; $display("FAIL basic_data: got %h required %h", r_data, 32'h4433_2211); end
    n_checks++;
    if (r_ack - r_acc != 256) begin n_fail++; $display("FAIL basic_latency: got %0d required 256", r_ack - r_acc); end
    n_checks++;
    if (r_first_rise - r_acc != 2) begin n_fail++; $display("FAIL basic_first_rise: got %0d required 2", r_first_rise - r_acc); end
    n_checks++;
    if (r_rises != 64) begin n_fail++; $display("FAIL basic_sck_rises: got %0d required 64", r_rises); end
    n_checks++;
    if (r_cs_at_ack !== 1'b1) begin n_fail++; $display("FAIL basic_cs_at_ack: got %b required 1", r_cs_at_ack); end
    @(negedge clk);
    n_checks++;
    if (ack2 !== 1'b0) begin n_fail++; $display("FAIL basic_ack_width: got ack=%b one cycle later, required 0", ack2); end
    n_checks++;
    if (dat2 !== 32'h4433_2211) begin n_fail++; $display("FAIL basic_dat_hold: got %h required %h", dat2, 32'h4433_2211); end
  endtask

  task automatic test_unaligned();
    @(negedge clk);
    run_read(1'b0, 32'hFF00_0106, 1'b0);
    n_checks++;
    if (cap !== 32'h0300_0104) begin n_fail++; $display("FAIL unaligned_mosi: got %h required %h", cap, 32'h0300_0104); end
    n_checks++;
    if (r_data !== 32'h4433_2211) begin n_fail++; $display("FAIL unaligned_data: got %h required %h", r_data, 32'h4433_2211); end
  endtask

  task automatic test_write();
    logic [31:0] dat_before;
    bit          bad_spi, bad_ack;
    @(negedge clk);
    dat_before = dat2;
    use1 = 1'b0; we = 1'b1; adr = $urandom; wdat = $urandom; cyc2 = 1'b1; stb2 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (err2 !== 1'b1 || ack2 !== 1'b0) begin
      n_fail++; $display("FAIL write_err: got err=%b ack=%b required err=1 ack=0", err2, ack2);
    end
    cyc2 = 1'b0; stb2 = 1'b0; we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err2 !== 1'b0) begin n_fail++; $display("FAIL write_err_width: got err=%b required 0", err2); end
    bad_spi = 1'b0; bad_ack = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cs2 !== 1'b1 || sck2 !== 1'b0) bad_spi = 1'b1;
      if (ack2 !== 1'b0 || err2 !== 1'b0) bad_ack = 1'b1;
    end
    n_checks++;
    if (bad_spi) begin n_fail++; $display("FAIL write_spi_idle: SPI activity seen, required cs_n=1 sck=0"); end
    n_checks++;
    if (bad_ack) begin n_fail++; $display("FAIL write_no_ack: stray ack/err seen, required none"); end
    n_checks++;
    if (dat2 !== dat_before) begin n_fail++; $display("FAIL write_dat: got %h required %h", dat2, dat_before); end
  endtask

  task automatic test_abort();
    logic [31:0] dat_before;
    bit          reached, got_resp;
    @(negedge clk);
    dat_before = dat2;
    use1 = 1'b0; we = 1'b0; adr = 32'h0000_0200; cyc2 = 1'b1; stb2 = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < 2000 && !reached; n++) begin
      @(negedge clk);
      if (m_cs_n === 1'b0 && in_bits >= 21) reached = 1'b1;
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL abort_reach: bit 20 never shifted, required within 2000 cycles"); end
    cyc2 = 1'b0; stb2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cs2, sck2, mosi2, ack2} !== 4'b1000) begin
      n_fail++; $display("FAIL abort_outputs: got cs_n=%b sck=%b mosi=%b ack=%b required 1/0/0/0", cs2, sck2, mosi2, ack2);
    end
    got_resp = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (ack2 !== 1'b0 || err2 !== 1'b0 || cs2 !== 1'b1) got_resp = 1'b1;
    end
    n_checks++;
    if (got_resp) begin n_fail++; $display("FAIL abort_quiet: response or cs activity after abort, required none"); end
    n_checks++;
    if (dat2 !== dat_before) begin n_fail++; $display("FAIL abort_dat: got %h required %h", dat2, dat_before); end
    run_read(1'b0, 32'h0000_0104, 1'b0);
    n_checks++;
    if (r_data !== 32'h4433_2211) begin n_fail++; $display("FAIL abort_reread: got %h required %h", r_data, 32'h4433_2211); end
  endtask

  task automatic test_reset_mid();
    bit reached, got_resp;
    @(negedge clk);
    use1 = 1'b0; we = 1'b0; adr = 32'h0000_0104; cyc2 = 1'b1; stb2 = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < 2000 && !reached; n++) begin
      @(negedge clk);
      if (m_cs_n === 1'b0 && in_bits >= 40) reached = 1'b1;
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL rstmid_reach: data phase not reached, required within 2000 cycles"); end
    rst = 1'b1; cyc2 = 1'b0; stb2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({dat2, ack2, err2, sck2, cs2, mosi2} !== {32'h0, 5'b00010}) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got dat=%h ack=%b err=%b sck=%b cs_n=%b mosi=%b, required 0/0/0/0/1/0",
               dat2, ack2, err2, sck2, cs2, mosi2);
    end
    got_resp = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (ack2 !== 1'b0 || cs2 !== 1'b1) got_resp = 1'b1;
    end
    n_checks++;
    if (got_resp) begin n_fail++; $display("FAIL rstmid_no_ack: ack or cs activity after reset, required none"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0;
    int          acc0, ack0, fr0, rises0;
    @(negedge clk);
    run_read(1'b1, 32'h0000_0000, 1'b1);
    d0 = r_data; acc0 = r_acc; ack0 = r_ack; fr0 = r_first_rise; rises0 = r_rises;
    run_read(1'b1, 32'h0000_0004, 1'b0);
    n_checks++;
    if (d0 !== exp_word(32'h0)) begin n_fail++; $display("FAIL b2b_data0: got %h required %h", d0, exp_word(32'h0)); end
    n_checks++;
    if (ack0 - acc0 != 128) begin n_fail++; $display("FAIL b2b_latency0: got %0d required 128", ack0 - acc0); end
    n_checks++;
    if (fr0 - acc0 != 1 || rises0 != 64) begin
      n_fail++; $display("FAIL b2b_sck0: first rise %0d rises %0d, required 1 and 64", fr0 - acc0, rises0);
    end
    n_checks++;
    if (r_acc - ack0 != 2) begin n_fail++; $display("FAIL b2b_reaccept: got %0d edges after ack, required 2", r_acc - ack0); end
    n_checks++;
    if (r_ack - r_acc != 128) begin n_fail++; $display("FAIL b2b_latency1: got %0d required 128", r_ack - r_acc); end
    n_checks++;
    if (r_data !== exp_word(32'h4)) begin n_fail++; $display("FAIL b2b_data1: got %h required %h", r_data, exp_word(32'h4)); end
    @(negedge clk);
    n_checks++;
    if (ack1 !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_width: got ack=%b required 0", ack1); end
  endtask

  task automatic test_random();
    bit          d1;
    logic [31:0] a;
    int          div;
    for (int i = 0; i < 8; i++) begin
      d1 = 1'($urandom_range(0, 1));
      a  = $urandom;
      div = d1 ? 1 : 2;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      run_read(d1, a, 1'b0);
      n_checks++;
      if (r_data !== exp_word(a)) begin n_fail++; $display("FAIL rand_data[%0d]: addr %h got %h required %h", i, a, r_data, exp_word(a)); end
      n_checks++;
      if (cap !== {8'h03, a[23:2], 2'b00}) begin
        n_fail++; $display("FAIL rand_mosi[%0d]: got %h required %h", i, cap, {8'h03, a[23:2], 2'b00});
      end
      n_checks++;
      if (r_ack - r_acc != 128 * div) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, r_ack - r_acc, 128 * div);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; adr = '0; wdat = '0; sel = 4'hF; we = 1'b0;
    cyc1 = 1'b0; stb1 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0; miso = 1'b0; use1 = 1'b0;
    test_reset();
    test_basic_read();
    test_unaligned();
    test_write();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
